// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target core and the i2c_core master.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic       I2C_READ     = 1'b1;
  localparam logic [6:0] I2C_GEN_CALL = 7'h00;
  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;

  // Address byte is {addr[6:0], rw}. General call is only honoured for writes.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] own,
                                      input logic       gen_call_en);
    logic own_hit;
    logic gc_hit;
    own_hit = (addr_byte[7:1] == own);
    gc_hit  = gen_call_en && (addr_byte[7:1] == I2C_GEN_CALL) && (addr_byte[0] != I2C_READ);
    return own_hit || gc_hit;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SDA/SCL synchronizers plus edge/condition detection on the synchronized lines.
// The two chains have equal depth, so the relative order of SDA and SCL
// transitions seen by the logic matches the pins.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sda_i,
  input  logic scl_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] sda_ff;
  logic [SYNC_STAGES-1:0] scl_ff;
  logic                   sda_prev;
  logic                   scl_prev;
  logic                   scl_s;

  // Synchronizer chains and edge-detect flops; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_ff   <= '1;
      scl_ff   <= '1;
      sda_prev <= 1'b1;
      scl_prev <= 1'b1;
    end else begin
      sda_ff   <= {sda_ff[SYNC_STAGES-2:0], sda_i};
      scl_ff   <= {scl_ff[SYNC_STAGES-2:0], scl_i};
      sda_prev <= sda_ff[SYNC_STAGES-1];
      scl_prev <= scl_ff[SYNC_STAGES-1];
    end
  end

  assign sda_s = sda_ff[SYNC_STAGES-1];
  assign scl_s = scl_ff[SYNC_STAGES-1];

  // SCL must be high on both sides of the SDA edge for a bus condition.
  always_comb begin
    scl_rise = scl_s & ~scl_prev;
    scl_fall = ~scl_s & scl_prev;
    start    = scl_s & scl_prev & sda_prev & ~sda_s;
    stop     = scl_s & scl_prev & ~sda_prev & sda_s;
  end

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target: address match, write deserialization, read serialization.
// SDA is open-drain style (0 = pull low, 1 = release); no clock stretching.
//
//   state        | meaning
//   ST_IDLE      | bus free, waiting for START
//   ST_ADDR      | shifting in the address byte
//   ST_ADDR_ACK  | driving ACK for a matched address
//   ST_RX_BYTE   | shifting in a data byte from the master
//   ST_RX_ACK    | driving ACK/NACK for a received byte
//   ST_TX_BYTE   | driving a data byte to the master
//   ST_TX_ACK    | SDA released, sampling the master's ACK
//   ST_WAIT_STOP | not addressed / finished; ignore bits until START or STOP
//
// phase_q splits the two-fall ACK slots (0: waiting for the fall that starts
// the slot, 1: waiting for the fall that ends it) and, in ST_TX_BYTE, marks
// that all 8 bits were clocked so the next fall releases SDA.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GEN_CALL_EN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] own_address,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       sda_o,
  input  logic       rx_ack_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sda_i    (sda_i),
    .scl_i    (scl_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e state_q,    state_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic [7:0] shift_q,    shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       phase_q,    phase_d;
  logic       ack_sel_q,  ack_sel_d;
  logic       rw_q,       rw_d;
  logic       busy_q,     busy_d;
  logic       sda_q,      sda_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q,   tx_req_d;
  logic       hit_q,      hit_d;
  logic [7:0] shift_in;
  logic       gen_call_on;

  assign shift_in    = {shift_q[6:0], sda_s};
  assign gen_call_on = (GEN_CALL_EN != 0);

  // State and datapath registers; reset releases SDA without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      phase_q    <= 1'b0;
      ack_sel_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      phase_q    <= phase_d;
      ack_sel_q  <= ack_sel_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_q      <= sda_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      hit_q      <= hit_d;
    end
  end

  // Next-state logic: STOP beats START, START beats any bit-level event.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    phase_d    = phase_q;
    ack_sel_d  = ack_sel_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_d      = sda_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    hit_d      = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (start) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
      phase_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_match(shift_in, own_address, gen_call_on)) begin
                rw_d    = shift_in[0];
                hit_d   = 1'b1;
                busy_d  = 1'b1;
                phase_d = 1'b0;
                state_d = ST_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_rise && rw_q == I2C_READ) begin
            tx_shift_d = tx_data;
            tx_req_d   = 1'b1;
          end
          if (scl_fall) begin
            if (!phase_q) begin
              sda_d   = I2C_ACK;
              phase_d = 1'b1;
            end else begin
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (rw_q == I2C_READ) begin
                sda_d      = tx_shift_q[7];
                tx_shift_d = {tx_shift_q[6:0], 1'b1};
                state_d    = ST_TX_BYTE;
              end else begin
                sda_d   = 1'b1;
                state_d = ST_RX_BYTE;
              end
            end
          end
        end

        ST_RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              ack_sel_d  = rx_ack_en;
              phase_d    = 1'b0;
              state_d    = ST_RX_ACK;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_d   = ack_sel_q ? I2C_ACK : I2C_NACK;
              phase_d = 1'b1;
            end else begin
              sda_d     = 1'b1;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (ack_sel_q) begin
                state_d = ST_RX_BYTE;
              end else begin
                busy_d  = 1'b0;
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // Bits are counted on rises; the fall after the 8th rise hands SDA back.
        ST_TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (phase_q) begin
              sda_d   = 1'b1;
              phase_d = 1'b0;
              state_d = ST_TX_ACK;
            end else begin
              sda_d      = tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b1};
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              tx_shift_d = tx_data;
              tx_req_d   = 1'b1;
              bit_cnt_d  = '0;
              phase_d    = 1'b0;
              state_d    = ST_TX_BYTE;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_WAIT_STOP;
            end
          end
        end

        ST_WAIT_STOP: begin
          sda_d = 1'b1;
        end

        default: begin
          sda_d = 1'b1;
        end
      endcase
    end
  end

  assign sda_o    = sda_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign addr_hit = hit_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Master-BFM bench for i2c_slave_core: SCL period 40 clk, target address 7'h01.
module tb_i2c_slave_core;

  localparam logic [6:0] OWN = 7'h01;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] own_address;
  logic       sda_m;
  logic       scl;
  logic       sda_o;
  logic       sda_line;
  logic       rx_ack_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addr_hit;
  logic       rw;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  int rxv_cnt = 0, txr_cnt = 0, hit_cnt = 0, low_cnt = 0, ovl_cnt = 0;
  logic [7:0] rx_log[$];
  logic [7:0] tx_arr[16];
  logic [3:0] tx_ptr = 4'd0;

  assign sda_line = sda_m & sda_o;
  assign tx_data  = tx_arr[tx_ptr];

  always #5 clk = ~clk;

  i2c_slave_core #(
    .SYNC_STAGES (2),
    .GEN_CALL_EN (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .own_address (own_address),
    .sda_i       (sda_line),
    .scl_i       (scl),
    .sda_o       (sda_o),
    .rx_ack_en   (rx_ack_en),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .addr_hit    (addr_hit),
    .rw          (rw),
    .busy        (busy)
  );

  // Host side: log received bytes, advance the transmit queue on each tx_req.
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_req) begin
      txr_cnt++;
      tx_ptr = tx_ptr + 4'd1;
    end
    if (addr_hit) hit_cnt++;
    if (rst_n && sda_o === 1'b0) low_cnt++;
    if ((int'(rx_valid) + int'(tx_req) + int'(addr_hit)) > 1) ovl_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    wait_clk(5);  sda_m = b;
    wait_clk(15); scl = 1'b1;
    wait_clk(10); s = sda_line;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic start_c;
    wait_clk(5);  sda_m = 1'b1;
    wait_clk(15); scl = 1'b1;
    wait_clk(10); sda_m = 1'b0;
    wait_clk(10); scl = 1'b0;
  endtask

  task automatic stop_c;
    wait_clk(5);  sda_m = 1'b0;
    wait_clk(15); scl = 1'b1;
    wait_clk(10); sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
    bit_xfer(mack, s);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sda_m = 1'b1; scl = 1'b1;
    wait_clk(3);
    n_cmp++; if (sda_o !== 1'b1) begin n_bad++; $display("FAIL rst_sda: got %b want 1", sda_o); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    n_cmp++; if ({rx_valid, tx_req, addr_hit} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {rx_valid, tx_req, addr_hit}); end
    n_cmp++; if ({rw, busy} !== 2'b00) begin n_bad++; $display("FAIL rst_rw_busy: got %b want 00", {rw, busy}); end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write(input int nbytes, input logic fixed);
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       a;
    int         rx0, hit0;
    rx0 = rx_log.size(); hit0 = hit_cnt;
    start_c;
    write_byte({OWN, 1'b0}, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL wr_addr_ack: got %b want 0", a); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", busy); end
    for (int k = 0; k < nbytes; k++) begin
      d = (fixed && k == 0) ? 8'h33 : 8'($urandom);
      write_byte(d, a);
      exp_q.push_back(d);
      n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL wr_data_ack%0d: got %b want 0", k, a); end
    end
    stop_c;
    wait_clk(4);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
    n_cmp++; if (rw !== 1'b0) begin n_bad++; $display("FAIL wr_rw: got %b want 0", rw); end
    n_cmp++; if (hit_cnt - hit0 != 1) begin n_bad++; $display("FAIL wr_hits: got %0d want 1", hit_cnt - hit0); end
    n_cmp++; if (rx_log.size() - rx0 != nbytes) begin n_bad++; $display("FAIL wr_rx_count: got %0d want %0d", rx_log.size() - rx0, nbytes); end
    for (int k = 0; k < nbytes && rx0 + k < rx_log.size(); k++) begin
      n_cmp++; if (rx_log[rx0 + k] !== exp_q[k]) begin n_bad++; $display("FAIL wr_rx_data%0d: got %h want %h", k, rx_log[rx0 + k], exp_q[k]); end
    end
  endtask

  task automatic test_mismatch;
    logic [6:0] adr;
    logic       a, r;
    int         low0, hit0, rxv0;
    low0 = low_cnt; hit0 = hit_cnt; rxv0 = rxv_cnt;
    for (int it = 0; it < 3; it++) begin
      if (it == 0)      begin adr = 7'h05; r = 1'b0; end
      else if (it == 1) begin adr = 7'h00; r = 1'b0; end
      else begin
        adr = 7'($urandom_range(2, 127));
        r   = 1'($urandom);
      end
      start_c;
      write_byte({adr, r}, a);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL mm_addr_ack%0d: got %b want 1", it, a); end
      write_byte(8'h55, a);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL mm_data_ack%0d: got %b want 1", it, a); end
      stop_c;
    end
    n_cmp++; if (low_cnt != low0) begin n_bad++; $display("FAIL mm_sda_low: got %0d clk low want 0", low_cnt - low0); end
    n_cmp++; if (hit_cnt != hit0) begin n_bad++; $display("FAIL mm_hits: got %0d want 0", hit_cnt - hit0); end
    n_cmp++; if (rxv_cnt != rxv0) begin n_bad++; $display("FAIL mm_rx_valid: got %0d want 0", rxv_cnt - rxv0); end
  endtask

  task automatic test_read(input int nbytes, input logic fixed);
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       a;
    int         txr0;
    txr0 = txr_cnt;
    for (int k = 0; k < nbytes; k++) begin
      if (fixed && k == 0)      d = 8'hA5;
      else if (fixed && k == 1) d = 8'h3C;
      else                      d = 8'($urandom);
      tx_arr[tx_ptr + 4'(k)] = d;
      exp_q.push_back(d);
    end
    start_c;
    write_byte({OWN, 1'b1}, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    n_cmp++; if (rw !== 1'b1) begin n_bad++; $display("FAIL rd_rw: got %b want 1", rw); end
    for (int k = 0; k < nbytes; k++) begin
      read_byte(d, (k == nbytes - 1) ? 1'b1 : 1'b0);
      n_cmp++; if (d !== exp_q[k]) begin n_bad++; $display("FAIL rd_data%0d: got %h want %h", k, d, exp_q[k]); end
    end
    wait_clk(5);
    n_cmp++; if (sda_o !== 1'b1) begin n_bad++; $display("FAIL rd_release: got %b want 1", sda_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_nack: got %b want 0", busy); end
    n_cmp++; if (txr_cnt - txr0 != nbytes) begin n_bad++; $display("FAIL rd_tx_req: got %0d want %0d", txr_cnt - txr0, nbytes); end
    stop_c;
  endtask

  task automatic test_repeated_start;
    logic [7:0] d, rd;
    logic       a;
    int         hit0;
    hit0 = hit_cnt;
    d = 8'($urandom);
    rd = 8'($urandom);
    tx_arr[tx_ptr] = rd;
    start_c;
    write_byte({OWN, 1'b0}, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL sr_addr1_ack: got %b want 0", a); end
    write_byte(d, a);
    start_c;
    write_byte({OWN, 1'b1}, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL sr_addr2_ack: got %b want 0", a); end
    n_cmp++; if (rw !== 1'b1) begin n_bad++; $display("FAIL sr_rw: got %b want 1", rw); end
    read_byte(d, 1'b1);
    n_cmp++; if (d !== rd) begin n_bad++; $display("FAIL sr_read: got %h want %h", d, rd); end
    stop_c;
    n_cmp++; if (hit_cnt - hit0 != 2) begin n_bad++; $display("FAIL sr_hits: got %0d want 2", hit_cnt - hit0); end
  endtask

  task automatic test_nack;
    logic a;
    int   rxv0, low0;
    rxv0 = rxv_cnt;
    rx_ack_en = 1'b0;
    start_c;
    write_byte({OWN, 1'b0}, a);
    n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL nk_addr_ack: got %b want 0", a); end
    write_byte(8'h77, a);
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL nk_data_ack: got %b want 1", a); end
    wait_clk(5);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nk_busy: got %b want 0", busy); end
    n_cmp++; if (rx_data !== 8'h77) begin n_bad++; $display("FAIL nk_rx_data: got %h want 77", rx_data); end
    rx_ack_en = 1'b1;
    low0 = low_cnt;
    for (int k = 0; k < 2; k++) begin
      write_byte(8'($urandom), a);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL nk_ignored_ack%0d: got %b want 1", k, a); end
    end
    stop_c;
    n_cmp++; if (low_cnt != low0) begin n_bad++; $display("FAIL nk_sda_low: got %0d clk low want 0", low_cnt - low0); end
    n_cmp++; if (rxv_cnt - rxv0 != 1) begin n_bad++; $display("FAIL nk_rx_valid: got %0d want 1", rxv_cnt - rxv0); end
  endtask

  task automatic test_abort;
    logic a, s;
    int   rxv0;
    rxv0 = rxv_cnt;
    start_c;
    write_byte({OWN, 1'b0}, a);
    for (int k = 0; k < 4; k++) bit_xfer(1'($urandom), s);
    stop_c;
    wait_clk(4);
    n_cmp++; if ({busy, sda_o} !== 2'b01) begin n_bad++; $display("FAIL ab_stop_idle: got busy,sda=%b want 01", {busy, sda_o}); end
    tx_arr[tx_ptr] = 8'h00;
    start_c;
    write_byte({OWN, 1'b1}, a);
    for (int k = 0; k < 3; k++) bit_xfer(1'b1, s);
    wait_clk(8);
    n_cmp++; if (sda_o !== 1'b0) begin n_bad++; $display("FAIL ab_drive_pre_rst: got %b want 0", sda_o); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sda_o !== 1'b1) begin n_bad++; $display("FAIL ab_async_release: got %b want 1", sda_o); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ab_rst_busy: got %b want 0", busy); end
    wait_clk(3);
    rst_n = 1'b1;
    stop_c;
    n_cmp++; if (rxv_cnt != rxv0) begin n_bad++; $display("FAIL ab_rx_valid: got %0d want 0", rxv_cnt - rxv0); end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 4; t++) begin
      if ($urandom_range(0, 1) == 0) test_write($urandom_range(1, 3), 1'b0);
      else                           test_read($urandom_range(1, 3), 1'b0);
    end
    n_cmp++; if (ovl_cnt != 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d clk want 0", ovl_cnt); end
  endtask

  initial begin
    own_address = OWN;
    rx_ack_en   = 1'b1;
    for (int i = 0; i < 16; i++) tx_arr[i] = 8'h00;
    test_reset;
    test_write(1, 1'b1);
    test_write(3, 1'b0);
    test_mismatch;
    test_read(2, 1'b1);
    test_read(3, 1'b0);
    test_repeated_start;
    test_nack;
    test_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
